// File: rtl/truth_table_sweeper_if.sv
// Bundle between the truth-table sweeper, its lab front-end and the function under test.
// The sweeper connects through the slave modport; the environment drives the master side.
interface truth_table_sweeper_if #(
  parameter int N_INPUTS = 5
);
  localparam int DEPTH = 1 << N_INPUTS;

  logic                start;
  logic [DEPTH-1:0]    expected;
  logic [N_INPUTS-1:0] dut_in;
  logic                dut_out;
  logic                busy;
  logic                done;
  logic                pass;
  logic [N_INPUTS:0]   mismatch_count;
  logic [N_INPUTS-1:0] first_fail;
  logic                fail_valid;
  logic [DEPTH-1:0]    obs_table;

  modport master (
    output start, expected, dut_out,
    input  dut_in, busy, done, pass, mismatch_count, first_fail, fail_valid, obs_table
  );

  modport slave (
    input  start, expected, dut_out,
    output dut_in, busy, done, pass, mismatch_count, first_fail, fail_valid, obs_table
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks an N-input combinational function through every minterm in ascending order,
// compares each settled output against a latched expected mask and records the results.
module truth_table_sweeper #(
  parameter int N_INPUTS      = 5,
  parameter int SETTLE_CYCLES = 1
) (
  input logic                  clk,
  input logic                  reset,
  truth_table_sweeper_if.slave bus
);
  localparam int DEPTH = 1 << N_INPUTS;
  localparam logic [N_INPUTS-1:0] LAST_IDX    = '1;
  localparam logic [3:0]          SETTLE_LAST = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e              state_q,  state_d;
  logic [N_INPUTS-1:0] index_q,  index_d;
  logic [3:0]          settle_q, settle_d;
  logic [DEPTH-1:0]    mask_q,   mask_d;
  logic [DEPTH-1:0]    obs_q,    obs_d;
  logic [N_INPUTS:0]   mm_q,     mm_d;
  logic [N_INPUTS-1:0] ff_q,     ff_d;
  logic                fv_q,     fv_d;

  // NOTE: every register, including the observed table, is cleared on reset so an
  // aborted sweep leaves no partial results; state updates use non-blocking assigns.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      index_q  <= '0;
      settle_q <= '0;
      mask_q   <= '0;
      obs_q    <= '0;
      mm_q     <= '0;
      ff_q     <= '0;
      fv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      settle_q <= settle_d;
      mask_q   <= mask_d;
      obs_q    <= obs_d;
      mm_q     <= mm_d;
      ff_q     <= ff_d;
      fv_q     <= fv_d;
    end
  end

  // NOTE: holding every next-state value at its current value first keeps this
  // block free of inferred latches.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    settle_d = settle_q;
    mask_d   = mask_q;
    obs_d    = obs_q;
    mm_d     = mm_q;
    ff_d     = ff_q;
    fv_d     = fv_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          mask_d   = bus.expected;
          obs_d    = '0;
          mm_d     = '0;
          ff_d     = '0;
          fv_d     = 1'b0;
          index_d  = '0;
          settle_d = '0;
          state_d  = S_APPLY;
        end
      end

      S_APPLY: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      S_SAMPLE: begin
        obs_d[index_q] = bus.dut_out;
        if (bus.dut_out != mask_q[index_q]) begin
          mm_d = mm_q + 1'b1;
          if (!fv_q) begin
            ff_d = index_q;
            fv_d = 1'b1;
          end
        end
        // The index stops at the last minterm so dut_in holds it while in DONE.
        if (index_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          index_d  = index_q + 1'b1;
          settle_d = '0;
          state_d  = S_APPLY;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.dut_in         = index_q;
  assign bus.busy           = (state_q == S_APPLY) || (state_q == S_SAMPLE);
  assign bus.done           = (state_q == S_DONE);
  assign bus.pass           = (state_q == S_DONE) && (mm_q == '0);
  assign bus.mismatch_count = mm_q;
  assign bus.first_fail     = ff_q;
  assign bus.fail_valid     = fv_q;
  assign bus.obs_table      = obs_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: one instance with a 1-cycle settle interval,
// one with no settle interval, each driving a selectable reference function.
module tb_truth_table_sweeper;
  localparam int N     = 5;
  localparam int DEPTH = 1 << N;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_INPUTS(N)) bus0 ();
  truth_table_sweeper_if #(.N_INPUTS(N)) bus1 ();

  truth_table_sweeper #(.N_INPUTS(N), .SETTLE_CYCLES(1)) u_sweep_s1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  truth_table_sweeper #(.N_INPUTS(N), .SETTLE_CYCLES(0)) u_sweep_s0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // 0: constant 0, 1: AND of all inputs, 2: XOR of all inputs
  int func0 = 0;
  int func1 = 0;

  function automatic logic fut(input int sel, input logic [N-1:0] v);
    case (sel)
      1:       return &v;
      2:       return ^v;
      default: return 1'b0;
    endcase
  endfunction

  assign bus0.dut_out = fut(func0, bus0.dut_in);
  assign bus1.dut_out = fut(func1, bus1.dut_in);

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_results0(input string tag, input logic pass, input int mm,
                                input int ff, input logic fv, input logic [31:0] obs);
    check({tag, "_done"},       bus0.done, 1'b1);
    check({tag, "_busy"},       bus0.busy, 1'b0);
    check({tag, "_pass"},       bus0.pass, pass);
    check({tag, "_mismatch"},   bus0.mismatch_count, mm);
    check({tag, "_first_fail"}, bus0.first_fail, ff);
    check({tag, "_fail_valid"}, bus0.fail_valid, fv);
    check({tag, "_obs_table"},  bus0.obs_table, obs);
    check({tag, "_dut_in"},     bus0.dut_in, DEPTH - 1);
  endtask

  // Runs one sweep on the settle=1 instance. Cycle count 1 is the start edge.
  // poke_at > 0 re-pulses start and flips expected mid-sweep.
  task automatic sweep0(input logic [31:0] mask, input int poke_at, output int lat);
    lat = 0;
    @(negedge clk);
    bus0.expected = mask;
    bus0.start    = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        bus0.start = 1'b0;
        check("busy_after_start", bus0.busy, 1'b1);
      end
      if (poke_at > 0 && c == poke_at) begin
        bus0.start    = 1'b1;
        bus0.expected = ~mask;
      end
      if (poke_at > 0 && c == poke_at + 1) bus0.start = 1'b0;
      if (bus0.done) begin
        lat = c;
        break;
      end
    end
  endtask

  int lat;

  initial begin
    reset         = 1'b1;
    bus0.start    = 1'b0;
    bus0.expected = '0;
    bus1.start    = 1'b0;
    bus1.expected = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dut_in",     bus0.dut_in, 0);
    check("rst_busy",       bus0.busy, 1'b0);
    check("rst_done",       bus0.done, 1'b0);
    check("rst_pass",       bus0.pass, 1'b0);
    check("rst_mismatch",   bus0.mismatch_count, 0);
    check("rst_fail_valid", bus0.fail_valid, 1'b0);
    check("rst_obs_table",  bus0.obs_table, 0);
    reset = 1'b0;

    // Constant 0 against an all-zero mask
    func0 = 0;
    sweep0(32'h0000_0000, 0, lat);
    check("zero_latency", lat, 97);
    check_results0("zero", 1'b1, 0, 0, 1'b0, 32'h0000_0000);

    // Constant 0 against an all-ones mask: every minterm fails
    sweep0(32'hFFFF_FFFF, 0, lat);
    check("ones_latency", lat, 97);
    check_results0("ones", 1'b0, 32, 0, 1'b1, 32'h0000_0000);

    // AND: only minterm 31 is high; mask also demands minterm 10
    func0 = 1;
    sweep0(32'h8000_0400, 0, lat);
    check("and_latency", lat, 97);
    check_results0("and", 1'b0, 1, 10, 1'b1, 32'h8000_0000);

    // start and expected changes mid-sweep are ignored
    func0 = 0;
    sweep0(32'h0000_0000, 20, lat);
    check("poke_latency", lat, 97);
    check_results0("poke", 1'b1, 0, 0, 1'b0, 32'h0000_0000);

    // Reset at cycle 40 of a sweep that has accumulated results
    func0 = 2;
    @(negedge clk);
    bus0.expected = 32'h0000_0000;
    bus0.start    = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      bus0.start = 1'b0;
    end
    check("pre_rst_mismatch_nonzero", bus0.mismatch_count != 0, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_dut_in",     bus0.dut_in, 0);
    check("midrst_busy",       bus0.busy, 1'b0);
    check("midrst_done",       bus0.done, 1'b0);
    check("midrst_mismatch",   bus0.mismatch_count, 0);
    check("midrst_first_fail", bus0.first_fail, 0);
    check("midrst_fail_valid", bus0.fail_valid, 1'b0);
    check("midrst_obs_table",  bus0.obs_table, 0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_stays_idle", bus0.busy, 1'b0);

    // Fresh sweep after the abort: parity mask for the XOR function
    sweep0(32'h9669_6996, 0, lat);
    check("xor_s1_latency", lat, 97);
    check_results0("xor_s1", 1'b1, 0, 0, 1'b0, 32'h9669_6996);

    // Reset wins over a simultaneous start
    @(negedge clk);
    reset      = 1'b1;
    bus0.start = 1'b1;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    bus0.start = 1'b0;
    check("rst_vs_start_busy", bus0.busy, 1'b0);
    check("rst_vs_start_done", bus0.done, 1'b0);
    @(posedge clk);
    #1;
    check("rst_vs_start_idle", bus0.busy, 1'b0);

    // Settle=0 instance with XOR: dut_in advances every 2 cycles
    func1 = 2;
    lat   = 0;
    @(negedge clk);
    bus1.expected = 32'h9669_6996;
    bus1.start    = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      bus1.start = 1'b0;
      check($sformatf("s0_dut_in_c%0d", c), bus1.dut_in, ((c - 1) / 2 > 31) ? 31 : (c - 1) / 2);
      if (bus1.done) begin
        lat = c;
        break;
      end
    end
    check("xor_s0_latency",   lat, 65);
    check("xor_s0_pass",      bus1.pass, 1'b1);
    check("xor_s0_mismatch",  bus1.mismatch_count, 0);
    check("xor_s0_obs_table", bus1.obs_table, 32'h9669_6996);

    // Complemented parity mask on the same instance: every minterm fails
    lat = 0;
    @(negedge clk);
    bus1.expected = 32'h6996_9669;
    bus1.start    = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      bus1.start = 1'b0;
      if (bus1.done) begin
        lat = c;
        break;
      end
    end
    check("xnor_s0_latency",    lat, 65);
    check("xnor_s0_pass",       bus1.pass, 1'b0);
    check("xnor_s0_mismatch",   bus1.mismatch_count, 32);
    check("xnor_s0_first_fail", bus1.first_fail, 0);
    check("xnor_s0_fail_valid", bus1.fail_valid, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
